// File: rtl/multicycle_main_control_pkg.sv
// multicycle_main_control_pkg: shared state encodings, opcodes, ALUOp and ALUSrcB selects, opcode-to-state decode
package multicycle_main_control_pkg;
  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_ALU_WB    = 4'd7,
    S_BRANCH    = 4'd8,
    S_ILLEGAL   = 4'd15
  } state_t;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BOFF = 2'b11;
  function automatic state_t decode_next(input logic [6:0] op);
    return (op == OP_LOAD || op == OP_STORE) ? S_MEM_ADDR :
           op == OP_RTYPE ? S_EXECUTE :
           op == OP_BRANCH ? S_BRANCH : S_ILLEGAL;
  endfunction
endpackage

// File: rtl/multicycle_main_control_if.sv
// multicycle_main_control_if: controller bus; master (controller) takes opcode/mem_ready, drives strobes, selects, illegal, state, instr_count
interface multicycle_main_control_if #(parameter int CNT_W = 16);
  logic [6:0] opcode;
  logic mem_ready;
  logic pc_write;
  logic pc_write_cond;
  logic i_or_d;
  logic mem_read;
  logic mem_write;
  logic ir_write;
  logic mem_to_reg;
  logic reg_write;
  logic alu_src_a;
  logic [1:0] alu_src_b;
  logic pc_source;
  logic [1:0] alu_op;
  logic illegal;
  logic [3:0] state;
  logic [CNT_W-1:0] instr_count;
  modport master (
    input opcode, mem_ready,
    output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
           reg_write, alu_src_a, alu_src_b, pc_source, alu_op, illegal, state, instr_count
  );
  modport slave (
    output opcode, mem_ready,
    input pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
          reg_write, alu_src_a, alu_src_b, pc_source, alu_op, illegal, state, instr_count
  );
endinterface

// File: rtl/multicycle_main_control_outdec.sv
// multicycle_main_control_outdec: combinational state-to-control decoder; inputs state/mem_ready/hold (strobe kill during reset), outputs all datapath controls
module multicycle_main_control_outdec
  import multicycle_main_control_pkg::*;
(
  input  state_t     state,
  input  logic       mem_ready,
  input  logic       hold,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       pc_source,
  output logic [1:0] alu_op,
  output logic       illegal
);
  always_comb begin
    pc_write = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d = 1'b0;
    mem_read = 1'b0;
    mem_write = 1'b0;
    ir_write = 1'b0;
    mem_to_reg = 1'b0;
    reg_write = 1'b0;
    alu_src_a = 1'b0;
    alu_src_b = SRCB_RS2;
    pc_source = 1'b0;
    alu_op = ALUOP_ADD;
    illegal = 1'b0;
    case (state)
      S_FETCH: begin
        mem_read = 1'b1;
        ir_write = mem_ready;
        pc_write = mem_ready;
        alu_src_b = SRCB_FOUR;
      end
      S_DECODE: alu_src_b = SRCB_BOFF;
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_MEM_READ: begin
        mem_read = 1'b1;
        i_or_d = 1'b1;
      end
      S_MEM_WB: begin
        reg_write = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        mem_write = 1'b1;
        i_or_d = 1'b1;
      end
      S_EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op = ALUOP_FUNCT;
      end
      S_ALU_WB: reg_write = 1'b1;
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op = ALUOP_SUB;
        pc_write_cond = 1'b1;
        pc_source = 1'b1;
      end
      S_ILLEGAL: illegal = 1'b1;
      default: illegal = 1'b0;
    endcase
    if (hold) {pc_write, pc_write_cond, mem_read, mem_write, ir_write, reg_write} = '0;
  end
endmodule

// File: rtl/multicycle_main_control.sv
// multicycle_main_control: multicycle RISC-V main control FSM; clk, async active-high reset, bus (master) carries opcode/mem_ready in and all controls, state, instr_count out
module multicycle_main_control
  import multicycle_main_control_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic reset,
  multicycle_main_control_if.master bus
);
  state_t state, nxt;
  logic is_load;
  logic [CNT_W-1:0] cnt;
  always_comb begin
    nxt = S_FETCH;
    case (state)
      S_FETCH:     nxt = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE:    nxt = decode_next(bus.opcode);
      S_MEM_ADDR:  nxt = is_load ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  nxt = bus.mem_ready ? S_MEM_WB : S_MEM_READ;
      S_MEM_WRITE: nxt = bus.mem_ready ? S_FETCH : S_MEM_WRITE;
      S_EXECUTE:   nxt = S_ALU_WB;
      S_ILLEGAL:   nxt = S_ILLEGAL;
      default:     nxt = S_FETCH;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_FETCH;
      is_load <= 1'b0;
      cnt <= '0;
    end else begin
      state <= nxt;
      if (state == S_DECODE) is_load <= bus.opcode == OP_LOAD;
      if (nxt == S_FETCH && state != S_FETCH) cnt <= cnt + CNT_W'(1);
    end
  end
  assign bus.state = state;
  assign bus.instr_count = cnt;
  multicycle_main_control_outdec u_outdec (
    .state(state),
    .mem_ready(bus.mem_ready),
    .hold(reset),
    .pc_write(bus.pc_write),
    .pc_write_cond(bus.pc_write_cond),
    .i_or_d(bus.i_or_d),
    .mem_read(bus.mem_read),
    .mem_write(bus.mem_write),
    .ir_write(bus.ir_write),
    .mem_to_reg(bus.mem_to_reg),
    .reg_write(bus.reg_write),
    .alu_src_a(bus.alu_src_a),
    .alu_src_b(bus.alu_src_b),
    .pc_source(bus.pc_source),
    .alu_op(bus.alu_op),
    .illegal(bus.illegal)
  );
endmodule

// File: tb/tb_multicycle_main_control.sv
// tb_multicycle_main_control: randomized self-checking bench against an instruction-level sequence model
module tb_multicycle_main_control;
  localparam int FETCH = 0, DECODE = 1, MADDR = 2, MREAD = 3, MWB = 4, MWRITE = 5;
  localparam int EXEC = 6, AWB = 7, BR = 8, ILL = 15;
  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011, BEQ = 7'b1100011;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [6:0] opcode = '0;
  logic mem_ready = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  int mcnt = 0;
  always #5 clk = ~clk;
  multicycle_main_control_if #(.CNT_W(16)) bus_a ();
  multicycle_main_control_if #(.CNT_W(2)) bus_b ();
  assign bus_a.opcode = opcode;
  assign bus_a.mem_ready = mem_ready;
  assign bus_b.opcode = opcode;
  assign bus_b.mem_ready = mem_ready;
  multicycle_main_control #(.CNT_W(16)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  multicycle_main_control #(.CNT_W(2)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));
  logic [14:0] ctrl_a;
  assign ctrl_a = {bus_a.pc_write, bus_a.pc_write_cond, bus_a.i_or_d, bus_a.mem_read, bus_a.mem_write,
                   bus_a.ir_write, bus_a.mem_to_reg, bus_a.reg_write, bus_a.alu_src_a, bus_a.alu_src_b,
                   bus_a.pc_source, bus_a.alu_op, bus_a.illegal};
  function automatic logic [14:0] exp_ctrl(input int st, input logic mr);
    logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rw, sa, psrc, ill;
    logic [1:0] sb, op;
    {pcw, pcwc, iord, mrd, mwr, irw, m2r, rw, sa, psrc, ill} = '0;
    sb = 2'b00;
    op = 2'b00;
    if (st == FETCH) begin mrd = 1; irw = mr; pcw = mr; sb = 2'b01; end
    if (st == DECODE) sb = 2'b11;
    if (st == MADDR) begin sa = 1; sb = 2'b10; end
    if (st == MREAD) begin mrd = 1; iord = 1; end
    if (st == MWB) begin rw = 1; m2r = 1; end
    if (st == MWRITE) begin mwr = 1; iord = 1; end
    if (st == EXEC) begin sa = 1; op = 2'b10; end
    if (st == AWB) rw = 1;
    if (st == BR) begin sa = 1; op = 2'b01; pcwc = 1; psrc = 1; end
    if (st == ILL) ill = 1;
    return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rw, sa, sb, psrc, op, ill};
  endfunction
  task automatic cycle(input int st, input logic mr, input logic [6:0] op);
    logic [14:0] e;
    mem_ready = mr;
    opcode = op;
    @(negedge clk);
    e = exp_ctrl(st, mr);
    vectors += 4;
    if (bus_a.state !== 4'(st)) begin
      miscompares++;
      $display("FAIL state: got %0d expected %0d", bus_a.state, st);
    end
    if (ctrl_a !== e) begin
      miscompares++;
      $display("FAIL ctrl st=%0d: got %b expected %b", st, ctrl_a, e);
    end
    if (bus_a.instr_count !== 16'(mcnt)) begin
      miscompares++;
      $display("FAIL count16: got %0d expected %0d", bus_a.instr_count, 16'(mcnt));
    end
    if (bus_b.instr_count !== 2'(mcnt)) begin
      miscompares++;
      $display("FAIL count2: got %0d expected %0d", bus_b.instr_count, 2'(mcnt));
    end
    @(posedge clk);
    #1;
  endtask
  function automatic logic [6:0] junk();
    return 7'($urandom);
  endfunction
  task automatic run_instr(input logic [6:0] op, input int fs, input int ms);
    for (int i = 0; i < fs; i++) cycle(FETCH, 1'b0, junk());
    cycle(FETCH, 1'b1, junk());
    cycle(DECODE, 1'($urandom), op);
    if (op == LW || op == SW) begin
      cycle(MADDR, 1'($urandom), junk());
      for (int i = 0; i < ms; i++) cycle(op == LW ? MREAD : MWRITE, 1'b0, junk());
      cycle(op == LW ? MREAD : MWRITE, 1'b1, junk());
      if (op == LW) cycle(MWB, 1'($urandom), junk());
    end else if (op == RT) begin
      cycle(EXEC, 1'($urandom), junk());
      cycle(AWB, 1'($urandom), junk());
    end else if (op == BEQ) begin
      cycle(BR, 1'($urandom), junk());
    end else begin
      for (int i = 0; i < 12; i++) cycle(ILL, 1'($urandom), junk());
      return;
    end
    mcnt++;
  endtask
  task automatic test_reset_start();
    reset = 1'b1;
    mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    mem_ready = 1'b0;
    @(posedge clk);
    #1;
    mcnt = 0;
  endtask
  task automatic test_rtype();
    run_instr(RT, 0, 0);
  endtask
  task automatic test_lw();
    run_instr(LW, 0, 2);
  endtask
  task automatic test_beq();
    run_instr(BEQ, 0, 0);
  endtask
  task automatic test_fetch_stall();
    run_instr(RT, 3, 0);
    run_instr(SW, 1, 1);
  endtask
  task automatic test_random();
    logic [6:0] ops [4];
    ops[0] = LW; ops[1] = SW; ops[2] = RT; ops[3] = BEQ;
    for (int n = 0; n < 40; n++) run_instr(ops[$urandom_range(3)], $urandom_range(2), $urandom_range(2));
  endtask
  task automatic test_reset_mid_access();
    cycle(FETCH, 1'b1, junk());
    cycle(DECODE, 1'b1, LW);
    cycle(MADDR, 1'b1, junk());
    cycle(MREAD, 1'b0, junk());
    mem_ready = 1'b1;
    #2 reset = 1'b1;
    #1;
    vectors += 4;
    if (bus_a.state !== 4'd0) begin
      miscompares++;
      $display("FAIL async_reset_state: got %0d expected 0", bus_a.state);
    end
    if (ctrl_a !== {9'b0, 2'b01, 4'b0}) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b expected %b", ctrl_a, {9'b0, 2'b01, 4'b0});
    end
    if (bus_a.instr_count !== 16'd0) begin
      miscompares++;
      $display("FAIL reset_count16: got %0d expected 0", bus_a.instr_count);
    end
    if (bus_b.instr_count !== 2'd0) begin
      miscompares++;
      $display("FAIL reset_count2: got %0d expected 0", bus_b.instr_count);
    end
    mcnt = 0;
    @(posedge clk);
    #1;
    vectors++;
    if (bus_a.mem_read !== 1'b0 || bus_a.ir_write !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_hold_strobes: got mr=%b irw=%b expected 0 0", bus_a.mem_read, bus_a.ir_write);
    end
    mem_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask
  task automatic test_wrap();
    for (int n = 0; n < 5; n++) run_instr(SW, 0, $urandom_range(2));
    vectors++;
    if (bus_b.instr_count !== 2'd1) begin
      miscompares++;
      $display("FAIL wrap_count2: got %0d expected 1", bus_b.instr_count);
    end
  endtask
  task automatic test_illegal();
    run_instr(7'b1111111, 0, 0);
  endtask
  initial begin
    test_reset_start();
    test_rtype();
    test_lw();
    test_beq();
    test_fetch_stall();
    test_random();
    test_reset_mid_access();
    test_wrap();
    test_illegal();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
